// File: rtl/quadrature_decoder_if.sv
// Encoder inputs, control requests and decoded outputs of the
// quadrature decoder, grouped as one bundle.
interface quadrature_decoder_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   enc_a;
    logic                   enc_b;
    logic                   count_latch;
    logic                   error_clear;
    logic                   qdec_inc;
    logic                   qdec_dec;
    logic                   qdec_error;
    logic [COUNT_WIDTH-1:0] count_data;
    logic                   count_valid;

    modport master (
        output enc_a, enc_b, count_latch, error_clear,
        input  qdec_inc, qdec_dec, qdec_error, count_data, count_valid
    );

    modport slave (
        input  enc_a, enc_b, count_latch, error_clear,
        output qdec_inc, qdec_dec, qdec_error, count_data, count_valid
    );
endinterface

// File: rtl/quadrature_decoder.sv
// Synchronise, glitch-filter and 4x-decode incremental encoder A/B into
// inc/dec strobes, with a saturating pulse accumulator and error flag.
module quadrature_decoder #(
    parameter int FILTER_LENGTH = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input logic                 clk,
    input logic                 reset,
    quadrature_decoder_if.slave bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [COUNT_WIDTH-1:0] MAX_V = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic [COUNT_WIDTH-1:0] MIN_V = {1'b1, {(COUNT_WIDTH-1){1'b0}}};

    state_t                 state_q, state_d;
    logic [1:0]             init_q, init_d;
    logic [1:0]             sync1_q, sync1_d;
    logic [1:0]             sync2_q, sync2_d;
    logic [1:0]             filt_q, filt_d;
    logic [1:0]             prev_q, prev_d;
    logic [1:0][7:0]        fcnt_q, fcnt_d;
    logic                   inc_q, inc_d;
    logic                   dec_q, dec_d;
    logic                   err_q, err_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] cdata_q, cdata_d;
    logic                   cvalid_q, cvalid_d;

    logic                   run;
    logic [1:0]             delta;
    logic                   fwd, rev, ill;
    logic [COUNT_WIDTH:0]   step_w, wide;
    logic [COUNT_WIDTH-1:0] sum;

    always_comb begin
        run      = (state_q == ST_RUN);
        state_d  = state_q;
        init_d   = init_q;
        sync1_d  = {bus.enc_a, bus.enc_b};
        sync2_d  = sync1_q;
        filt_d   = filt_q;
        fcnt_d   = fcnt_q;

        if (!run) begin
            filt_d = sync2_q;
            fcnt_d = '0;
            init_d = init_q + 2'd1;
            if (init_q == 2'd2) state_d = ST_RUN;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_d[i] = 8'd0;
                end else if (({1'b0, fcnt_q[i]} + 9'd1) == 9'(FILTER_LENGTH)) begin
                    filt_d[i] = sync2_q[i];
                    fcnt_d[i] = 8'd0;
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 8'd1;
                end
            end
        end

        // Keep prev in step with filt during INIT so RUN starts without a phantom edge.
        prev_d = run ? filt_q : filt_d;

        delta = filt_q ^ prev_q;
        fwd   = 1'b0;
        rev   = 1'b0;
        ill   = 1'b0;
        unique case (delta)
            2'b11: ill = 1'b1;
            2'b10: begin
                fwd = (prev_q[1] == prev_q[0]);
                rev = (prev_q[1] != prev_q[0]);
            end
            2'b01: begin
                fwd = (prev_q[1] != prev_q[0]);
                rev = (prev_q[1] == prev_q[0]);
            end
            default: ;
        endcase

        inc_d = run ? fwd : inc_q;
        dec_d = run ? rev : dec_q;
        err_d = run ? (ill | (err_q & ~bus.error_clear)) : err_q;

        step_w = '0;
        if (inc_q) step_w = (COUNT_WIDTH+1)'(1);
        else if (dec_q) step_w = '1;
        wide = {acc_q[COUNT_WIDTH-1], acc_q} + step_w;
        if (wide[COUNT_WIDTH] != wide[COUNT_WIDTH-1])
            sum = wide[COUNT_WIDTH] ? MIN_V : MAX_V;
        else
            sum = wide[COUNT_WIDTH-1:0];

        acc_d    = sum;
        cdata_d  = cdata_q;
        cvalid_d = bus.count_latch;
        if (bus.count_latch) begin
            cdata_d = sum;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_INIT;
            init_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= '0;
            prev_q   <= '0;
            fcnt_q   <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            cdata_q  <= '0;
            cvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            filt_q   <= filt_d;
            prev_q   <= prev_d;
            fcnt_q   <= fcnt_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            cdata_q  <= cdata_d;
            cvalid_q <= cvalid_d;
        end
    end

    assign bus.qdec_inc    = inc_q;
    assign bus.qdec_dec    = dec_q;
    assign bus.qdec_error  = err_q;
    assign bus.count_data  = cdata_q;
    assign bus.count_valid = cvalid_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: directed encoder steps push
// expected strobes/counts, a negedge monitor pops and compares them.
module tb_quadrature_decoder;
    localparam int FL = 4;
    localparam int CW = 4;

    typedef struct {
        int val;
        int at;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    quadrature_decoder_if #(.COUNT_WIDTH(CW)) bus ();

    quadrature_decoder #(
        .FILTER_LENGTH(FL),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   pos = 2;
    exp_t strobe_q[$];
    exp_t count_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.qdec_inc && bus.qdec_dec) chk("inc_dec_exclusive", 1, 0);
        if (bus.qdec_inc || bus.qdec_dec) begin
            if (strobe_q.size() == 0) begin
                chk("unexpected_strobe", bus.qdec_inc ? 1 : -1, 0);
            end else begin
                e = strobe_q.pop_front();
                chk("strobe_dir", bus.qdec_inc ? 1 : -1, e.val);
                chk("strobe_cycle", cyc, e.at);
            end
        end
        if (bus.count_valid) begin
            if (count_q.size() == 0) begin
                chk("unexpected_count_valid", 1, 0);
            end else begin
                e = count_q.pop_front();
                chk("count_data", int'($signed(bus.count_data)), e.val);
                chk("count_valid_cycle", cyc, e.at);
            end
        end
    end

    function automatic logic [1:0] pat(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        bus.enc_a = ab[1];
        bus.enc_b = ab[0];
    endtask

    task automatic step(input int dir, input int hold);
        pos = (pos + dir + 4) % 4;
        drive_ab(pat(pos));
        strobe_q.push_back('{dir, cyc + FL + 3});
        idle(hold);
    endtask

    task automatic latch(input int exp);
        bus.count_latch = 1'b1;
        count_q.push_back('{exp, cyc + 1});
        @(negedge clk);
        bus.count_latch = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inc"}, int'(bus.qdec_inc), 0);
        chk({tag, "_dec"}, int'(bus.qdec_dec), 0);
        chk({tag, "_err"}, int'(bus.qdec_error), 0);
        chk({tag, "_cvalid"}, int'(bus.count_valid), 0);
        chk({tag, "_cdata"}, int'(bus.count_data), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: no finish by cycle %0d, expected earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.count_latch = 1'b0;
        bus.error_clear = 1'b0;
        drive_ab(2'b11);
        idle(3);
        chk_reset_outputs("reset");
        reset = 1'b1;
        idle(20);
        chk("init_err", int'(bus.qdec_error), 0);
        chk("init_cdata", int'(bus.count_data), 0);

        // four forward steps, then back-to-back latches
        repeat (4) step(1, 20);
        latch(4);
        latch(0);
        idle(5);

        // 3-clk glitch ignored, 4-clk pulse accepted both ways
        drive_ab(2'b01);
        idle(3);
        drive_ab(2'b11);
        idle(20);
        step(1, 4);
        step(-1, 20);

        // reach 00, then illegal 00->11
        step(1, 20);
        step(1, 20);
        pos = 2;
        drive_ab(2'b11);
        idle(12);
        chk("illegal_sets_err", int'(bus.qdec_error), 1);
        idle(10);
        chk("err_sticky", int'(bus.qdec_error), 1);

        // clear coinciding with another illegal transition
        pos = 0;
        drive_ab(2'b00);
        idle(FL + 2);
        bus.error_clear = 1'b1;
        idle(1);
        bus.error_clear = 1'b0;
        chk("set_wins_over_clear", int'(bus.qdec_error), 1);
        step(1, 12);
        chk("decode_while_err", int'(bus.qdec_error), 1);
        bus.error_clear = 1'b1;
        idle(1);
        bus.error_clear = 1'b0;
        chk("err_cleared", int'(bus.qdec_error), 0);
        latch(3);
        idle(3);

        // saturation
        repeat (10) step(1, 12);
        latch(7);
        repeat (10) step(-1, 12);
        latch(-8);
        idle(3);

        // latch in the cycle qdec_dec is high, accumulator at 3
        repeat (3) step(1, 12);
        step(-1, FL + 3);
        latch(2);
        idle(10);
        latch(0);
        step(1, 12);
        latch(1);
        step(1, 12);

        // illegal 10->01, then reset mid-step
        pos = 3;
        drive_ab(2'b01);
        idle(12);
        chk("err_before_reset", int'(bus.qdec_error), 1);
        pos = 0;
        drive_ab(2'b00);
        idle(3);
        reset = 1'b0;
        idle(2);
        chk_reset_outputs("midrun_reset");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("post_reset_no_strobe", int'(bus.qdec_inc | bus.qdec_dec), 0);
        end
        idle(20);
        step(1, 20);
        latch(1);
        idle(5);

        chk("strobes_outstanding", strobe_q.size(), 0);
        chk("counts_outstanding", count_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
